// File: rtl/i1404_dly_pkg.sv
// Shared types and helpers for the i1404 word delay line.
package i1404_dly_pkg;

  // Occupancy state, derived from the fill count
  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2
  } dly_state_e;

  localparam int DLY_WIDTH_DEF = 1;
  localparam int DLY_DEPTH_DEF = 1024;

  // Limit a tap index to the last physical stage
  function automatic logic [31:0] clamp_sel(input logic [31:0] sel, input logic [31:0] depth);
    return (sel >= depth) ? (depth - 32'd1) : sel;
  endfunction

endpackage

// File: rtl/i1404_dly_ctrl.sv
// Fill tracking for the delay line: fill counter, occupancy FSM,
// full flag and tap-valid qualification.
module i1404_dly_ctrl
  import i1404_dly_pkg::*;
#(
  parameter int DEPTH = DLY_DEPTH_DEF,
  parameter int SELW  = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en_i,
  input  logic            clear_i,
  input  logic            recirc_i,
  input  logic [SELW-1:0] tap_i,
  output logic [SELW:0]   fill_cnt_o,
  output logic            full_o,
  output logic            dout_valid_o
);

  localparam logic [SELW:0] FILL_MAX = (SELW+1)'(DEPTH);
  localparam logic [SELW:0] FILL_ONE = (SELW+1)'(1);

  dly_state_e     state_q, state_d;
  logic [SELW:0]  fill_q, fill_d;

  // State and fill registers; reset returns the line to EMPTY
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      fill_q  <= '0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
    end
  end

  // Next fill count and state: clear wins, recirculation keeps the count
  always_comb begin
    fill_d = fill_q;
    if (clear_i) begin
      fill_d = '0;
    end else if (en_i && !recirc_i && (fill_q != FILL_MAX)) begin
      fill_d = fill_q + FILL_ONE;
    end
    if (fill_d == '0) begin
      state_d = EMPTY;
    end else if (fill_d == FILL_MAX) begin
      state_d = FULL;
    end else begin
      state_d = FILLING;
    end
  end

  // Outputs: a tap is valid only once enough stages hold real data
  always_comb begin
    full_o       = (state_q == FULL);
    dout_valid_o = (fill_q > {1'b0, tap_i});
  end

  assign fill_cnt_o = fill_q;

endmodule

// File: rtl/tt_um_i1404_dly.sv
// Tapped WIDTH x DEPTH delay line / pattern replay engine.
// Optional per-stage even parity is enabled with `define I1404_DLY_PARITY_EN.
// Storage flops are deliberately unreset; stale contents are hidden by
// dout_valid. In the TinyTapeout wrapper: ui_in[0]=en, ui_in[1]=clear,
// ui_in[2]=recirc, uio_in[0]=din, uo_out[0]=dout, delay_sel on ui_in[7:3]
// plus spare uio bits.
module tt_um_i1404_dly
  import i1404_dly_pkg::*;
#(
  parameter  int WIDTH = DLY_WIDTH_DEF,
  parameter  int DEPTH = DLY_DEPTH_DEF,
  localparam int SELW  = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clear,
  input  logic             recirc,
  input  logic [WIDTH-1:0] din,
  input  logic [SELW-1:0]  delay_sel,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic [SELW:0]    fill_cnt,
  output logic             full
`ifdef I1404_DLY_PARITY_EN
  ,
  output logic             parity_err
`endif
);

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage0_d;
  logic [SELW-1:0]  tap_sel;
  logic             shift;

  // clear suppresses the shift so the stored words stay where they are
  assign shift   = en & ~clear;
  assign tap_sel = SELW'(clamp_sel(32'(delay_sel), 32'(DEPTH)));

  // Stage 0 source: fresh input, or the oldest word when replaying
  always_comb begin
    stage0_d = recirc ? stage_q[DEPTH-1] : din;
  end

  // Shift chain, advancing only on enabled cycles
  always_ff @(posedge clk) begin
    if (shift) begin
      stage_q[0] <= stage0_d;
      for (int i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

`ifdef I1404_DLY_PARITY_EN
  logic par_q [DEPTH];
  logic par0_d;

  // Parity source: computed at entry, carried unchanged when recirculating
  always_comb begin
    par0_d = recirc ? par_q[DEPTH-1] : ^din;
  end

  // Parity chain shifts in lock-step with the data chain
  always_ff @(posedge clk) begin
    if (shift) begin
      par_q[0] <= par0_d;
      for (int i = 1; i < DEPTH; i++) begin
        par_q[i] <= par_q[i-1];
      end
    end
  end

  assign parity_err = dout_valid & ((^stage_q[tap_sel]) != par_q[tap_sel]);
`endif

  i1404_dly_ctrl #(
    .DEPTH (DEPTH),
    .SELW  (SELW)
  ) u_ctrl (
    .clk          (clk),
    .rst_n        (rst_n),
    .en_i         (en),
    .clear_i      (clear),
    .recirc_i     (recirc),
    .tap_i        (tap_sel),
    .fill_cnt_o   (fill_cnt),
    .full_o       (full),
    .dout_valid_o (dout_valid)
  );

  // Tap mux, masked to zero whenever the selected stage is not yet valid
  always_comb begin
    dout = dout_valid ? stage_q[tap_sel] : '0;
  end

endmodule

// File: tb/tb_tt_um_i1404_dly.sv
// Bench for tt_um_i1404_dly: a short WIDTH=4/DEPTH=12 line checked every
// cycle against a queue model, plus a default 1x1024 line for full delay.
module tb_tt_um_i1404_dly;

  localparam int W   = 4;
  localparam int D   = 12;
  localparam int SW  = $clog2(D);
  localparam int LD  = 1024;
  localparam int LSW = $clog2(LD);

  logic clk = 1'b0;
  logic rst_n;

  logic          en, clear, recirc;
  logic [W-1:0]  din;
  logic [SW-1:0] delay_sel;
  logic [W-1:0]  dout;
  logic          dout_valid;
  logic [SW:0]   fill_cnt;
  logic          full;

  logic           l_en, l_clear, l_recirc;
  logic [0:0]     l_din;
  logic [LSW-1:0] l_sel;
  logic [0:0]     l_dout;
  logic           l_valid;
  logic [LSW:0]   l_fill;
  logic           l_full;

`ifdef I1404_DLY_PARITY_EN
  logic parity_err, l_parity_err;
`endif

  int n_checks = 0;
  int n_errors = 0;

  logic [W-1:0] mq[$];
  int           mfill;

  always #5 clk = ~clk;

  tt_um_i1404_dly #(.WIDTH(W), .DEPTH(D)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .clear      (clear),
    .recirc     (recirc),
    .din        (din),
    .delay_sel  (delay_sel),
    .dout       (dout),
    .dout_valid (dout_valid),
    .fill_cnt   (fill_cnt),
    .full       (full)
`ifdef I1404_DLY_PARITY_EN
    ,
    .parity_err (parity_err)
`endif
  );

  tt_um_i1404_dly #(.WIDTH(1), .DEPTH(LD)) dut_long (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (l_en),
    .clear      (l_clear),
    .recirc     (l_recirc),
    .din        (l_din),
    .delay_sel  (l_sel),
    .dout       (l_dout),
    .dout_valid (l_valid),
    .fill_cnt   (l_fill),
    .full       (l_full)
`ifdef I1404_DLY_PARITY_EN
    ,
    .parity_err (l_parity_err)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive inputs at the falling edge, then compare against the model
  task automatic drive_check(input logic e, input logic c, input logic r,
                             input logic [W-1:0] d, input logic [SW-1:0] s);
    int           esel;
    logic         ev;
    logic [W-1:0] ed;
    @(negedge clk);
    en = e; clear = c; recirc = r; din = d; delay_sel = s;
    #1;
    esel = (int'(s) >= D) ? D - 1 : int'(s);
    ev   = (mfill > esel);
    ed   = ev ? mq[esel] : '0;
    chk("dout",       32'(dout),       32'(ed));
    chk("dout_valid", 32'(dout_valid), 32'(ev));
    chk("fill_cnt",   32'(fill_cnt),   32'(mfill));
    chk("full",       32'(full),       32'(mfill == D));
`ifdef I1404_DLY_PARITY_EN
    chk("parity_err", 32'(parity_err), 32'd0);
`endif
  endtask

  // Model update at the rising edge: newest word at index 0
  task automatic tick();
    logic [W-1:0] w;
    @(posedge clk);
    if (clear) begin
      mfill = 0;
    end else if (en) begin
      if (recirc) begin
        w = (mq.size() == D) ? mq[D-1] : '0;
      end else begin
        w = din;
        if (mfill < D) mfill++;
      end
      mq.push_front(w);
      if (mq.size() > D) void'(mq.pop_back());
    end
  endtask

  task automatic step(input logic e, input logic c, input logic r,
                      input logic [W-1:0] d, input logic [SW-1:0] s);
    drive_check(e, c, r, d, s);
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    en = 1'b0; clear = 1'b0; recirc = 1'b0; din = '0; delay_sel = '0;
    l_en = 1'b0; l_clear = 1'b0; l_recirc = 1'b0; l_din = '0; l_sel = '0;
    mfill = 0;
    #2;
    chk("rst_fill",       32'(fill_cnt),   32'd0);
    chk("rst_valid",      32'(dout_valid), 32'd0);
    chk("rst_dout",       32'(dout),       32'd0);
    chk("rst_full",       32'(full),       32'd0);
    chk("rst_long_fill",  32'(l_fill),     32'd0);
    chk("rst_long_valid", 32'(l_valid),    32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Full-length delay on the 1x1024 line
    @(negedge clk);
    l_en = 1'b1; l_din = 1'b1; l_sel = LSW'(LD - 1);
    for (int i = 1; i <= LD + 1; i++) begin
      @(posedge clk);
      #1;
      l_din = 1'b0;
      if (i == LD - 1) begin
        chk("long_valid_early", 32'(l_valid), 32'd0);
        chk("long_dout_early",  32'(l_dout),  32'd0);
      end
      if (i == LD) begin
        chk("long_valid", 32'(l_valid), 32'd1);
        chk("long_dout",  32'(l_dout),  32'd1);
        chk("long_full",  32'(l_full),  32'd1);
        chk("long_fill",  32'(l_fill),  32'(LD));
      end
      if (i == LD + 1) begin
        chk("long_dout_next", 32'(l_dout), 32'd0);
      end
    end
    l_en = 1'b0;

    // Short tap with enable gaps
    step(1'b0, 1'b1, 1'b0, 4'h0, 4'd3);
    step(1'b1, 1'b0, 1'b0, 4'hA, 4'd3);
    step(1'b0, 1'b0, 1'b0, 4'h5, 4'd3);
    step(1'b1, 1'b0, 1'b0, 4'h5, 4'd3);
    step(1'b1, 1'b0, 1'b0, 4'h5, 4'd3);
    step(1'b1, 1'b0, 1'b0, 4'h5, 4'd3);
    drive_check(1'b0, 1'b0, 1'b0, 4'h0, 4'd3);
    chk("gap_dout", 32'(dout),     32'hA);
    chk("gap_fill", 32'(fill_cnt), 32'd4);
    tick();

    // Fill to FULL with 1..12 then replay
    step(1'b0, 1'b1, 1'b0, 4'h0, 4'd11);
    for (int k = 1; k <= D; k++) step(1'b1, 1'b0, 1'b0, W'(k), 4'd11);
    for (int k = 0; k < 30; k++) begin
      drive_check(1'b1, 1'b0, 1'b1, 4'h0, 4'd11);
      chk("recirc_dout", 32'(dout),     32'((k % D) + 1));
      chk("recirc_fill", 32'(fill_cnt), 32'(D));
      chk("recirc_full", 32'(full),     32'd1);
      tick();
    end

    // Out-of-range tap clamps to the last stage
    drive_check(1'b0, 1'b0, 1'b0, 4'h0, 4'd15);
    chk("clamp_dout", 32'(dout), 32'd7);
    tick();

    // clear beats en
    step(1'b1, 1'b1, 1'b0, 4'h9, 4'd11);
    drive_check(1'b0, 1'b0, 1'b0, 4'h0, 4'd11);
    chk("clr_fill",  32'(fill_cnt),   32'd0);
    chk("clr_valid", 32'(dout_valid), 32'd0);
    chk("clr_dout",  32'(dout),       32'd0);
    chk("clr_full",  32'(full),       32'd0);
    tick();

    // Asynchronous reset in the middle of filling
    for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 1'b0, W'($urandom), 4'd2);
    @(negedge clk);
    en = 1'b0; delay_sel = 4'd2;
    #1;
    chk("pre_rst_fill",  32'(fill_cnt),   32'd5);
    chk("pre_rst_valid", 32'(dout_valid), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_fill",  32'(fill_cnt),   32'd0);
    chk("arst_valid", 32'(dout_valid), 32'd0);
    chk("arst_dout",  32'(dout),       32'd0);
    #1;
    rst_n = 1'b1;
    mq.delete();
    mfill = 0;

    // Randomised traffic against the queue model
    for (int n = 0; n < 400; n++) begin
      logic c, r, e;
      c = ($urandom_range(0, 39) == 0);
      r = (mfill == D) && ($urandom_range(0, 2) != 0);
      e = ($urandom_range(0, 3) != 0);
      step(e, c, r, W'($urandom), SW'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
